mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency memory between the CPU's instruction-fetch port (read-only)
//  and data-memory port (load/store). Sits between the CPU and a unified memory; grants one transaction
//  at a time, round-robin when both request, and returns a one-cycle ack with read data per requester.
//  The CPU holds each *_req high until its *_ack, using it as a stall condition.
// PARAMETERS
//  ADDR_WIDTH   12  word-address width (byte address bits [13:2])
//  DATA_WIDTH   32  data word width
//  MEM_LATENCY  1   cycles from mem_en to valid mem_rdata; legal range 1..15
// PORTS
//  clk        in   1           clock; all state changes on posedge
//  reset      in   1           synchronous, active-low reset
//  if_req     in   1           fetch request; held high until if_ack
//  if_addr    in   ADDR_WIDTH fetch word address; stable while if_req is high
//  if_ack     out  1           one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DATA_WIDTH last fetched word; held until the next fetch ack
//  dm_req     in   1           data request; held high until dm_ack
//  dm_we      in   1           1=store, 0=load; stable while dm_req is high
//  dm_addr    in   ADDR_WIDTH data word address
//  dm_wdata   in   DATA_WIDTH store data
//  dm_ack     out  1           one-cycle pulse: data access complete
//  dm_rdata   out  DATA_WIDTH last loaded word; not updated by stores
//  mem_en     out  1           one-cycle memory strobe
//  mem_we     out  1           memory write enable; qualified by mem_en
//  mem_addr   out  ADDR_WIDTH memory word address
//  mem_wdata  out  DATA_WIDTH memory write data
//  mem_rdata  in   DATA_WIDTH memory read data; valid MEM_LATENCY cycles after the mem_en cycle
//  busy       out  1           1 whenever state != IDLE
//  owner      out  1           current/last grant: 0=IF, 1=DM
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, cnt=0, last_grant=1 (IF wins the first tie).
//   All outputs are 0, including rdata registers and owner. Any transaction in flight is abandoned;
//   its ack never fires and late mem_rdata is ignored.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: if no request, remain in IDLE. Otherwise select the winner:
//   - Only one requester active: grant it.
//   - Both active: grant ~last_grant.
//   Latch owner, addr, wdata and we (we forced 0 for IF); set last_grant=owner; go to ISSUE.
//  ISSUE: mem_en=1 for exactly this cycle; cnt<=MEM_LATENCY-1; go to WAIT.
//  WAIT: if cnt==0, register mem_rdata into the owner's rdata (reads only) and go to DONE;
//   else cnt<=cnt-1.
//  DONE: pulse the owner's ack for 1 cycle, then unconditionally go to IDLE. Any req seen in DONE is
//   ignored; a still-high req is re-arbitrated in the following IDLE cycle.
//  Timing: req sampled in IDLE at cycle T -> mem_en at T+1 -> capture at T+1+MEM_LATENCY ->
//   ack at T+2+MEM_LATENCY. Minimum spacing between grants is MEM_LATENCY+3 cycles.
//  mem_addr, mem_we and mem_wdata are registered and held stable from ISSUE through DONE.
//   mem_en is 0 in every state except ISSUE. if_ack and dm_ack are never high in the same cycle.
//  Requester changing addr/we/wdata or dropping req before ack is a protocol error.
//   The latched transaction still completes and acks.
//  Reset asserted in any state has priority over every transition.
// TESTING
//  T1 reset: hold reset=0 for 3 cycles with if_req=dm_req=1 -> all outputs 0, busy=0, no mem_en.
//  T2 fetch, L=1: if_req at T, if_addr=0x004, mem returns 0xDEADBEEF
//     -> mem_en=1 with mem_addr=0x004 at T+1; if_ack at T+3; if_rdata=0xDEADBEEF.
//  T3 store, L=1: dm_req=1, dm_we=1, dm_addr=0x010, dm_wdata=0x12345678
//     -> mem_en=mem_we=1 at T+1 with that addr/data; dm_ack at T+3; dm_rdata unchanged.
//  T4 contention: both reqs held high continuously after reset -> grants go IF, DM, IF, DM.
//     owner toggles; acks land 4 cycles apart (L=1).
//  T5 latency, L=3: dm load at T -> mem_addr stable T+1..T+5; mem_en only at T+1;
//     dm_ack at T+5 carrying the mem_rdata value presented at T+4.
//  T6 reset mid-WAIT (L=3): reset=0 at T+2 -> IDLE next cycle; no ack for that request.
//     last_grant=1, so IF wins the next tie.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port, fixed-latency memory between
// the instruction-fetch port and the load/store data port.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_ack_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_ack_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o,
    output logic                  owner_o
);
    // state | meaning
    // IDLE  | arbitrate between pending requests
    // ISSUE | single-cycle memory strobe, latency counter loaded
    // WAIT  | count down to read-data valid, capture on zero
    // DONE  | one-cycle ack to the owner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  grant_dm;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        grant_dm     = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req_i || dm_req_i) begin
                    // On a tie the port that did not win last time is served.
                    grant_dm     = dm_req_i && (!if_req_i || !last_grant_q);
                    owner_d      = grant_dm;
                    last_grant_d = grant_dm;
                    addr_d       = grant_dm ? dm_addr_i : if_addr_i;
                    we_d         = grant_dm && dm_we_i;
                    wdata_d      = dm_wdata_i;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q) dm_rdata_d = mem_rdata_i;
                        else         if_rdata_d = mem_rdata_i;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_en_o    = (state_q == ISSUE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_ack_o    = (state_q == DONE) && !owner_q;
    assign dm_ack_o    = (state_q == DONE) && owner_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 runs with latency 1, instance 1 with
// latency 3, each against a behavioural memory and a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n  [2];
    logic          if_req   [2];
    logic [AW-1:0] if_addr  [2];
    logic          if_ack   [2];
    logic [DW-1:0] if_rdata [2];
    logic          dm_req   [2];
    logic          dm_we    [2];
    logic [AW-1:0] dm_addr  [2];
    logic [DW-1:0] dm_wdata [2];
    logic          dm_ack   [2];
    logic [DW-1:0] dm_rdata [2];
    logic          mem_en   [2];
    logic          mem_we   [2];
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] mem_wdata[2];
    logic [DW-1:0] mem_rdata[2];
    logic          busy     [2];
    logic          owner    [2];

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .reset_i(reset_n[0]),
        .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_ack_o(if_ack[0]), .if_rdata_o(if_rdata[0]),
        .dm_req_i(dm_req[0]), .dm_we_i(dm_we[0]), .dm_addr_i(dm_addr[0]), .dm_wdata_i(dm_wdata[0]),
        .dm_ack_o(dm_ack[0]), .dm_rdata_o(dm_rdata[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0]), .owner_o(owner[0]));

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) u_dut_l3 (
        .clk_i(clk), .reset_i(reset_n[1]),
        .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_ack_o(if_ack[1]), .if_rdata_o(if_rdata[1]),
        .dm_req_i(dm_req[1]), .dm_we_i(dm_we[1]), .dm_addr_i(dm_addr[1]), .dm_wdata_i(dm_wdata[1]),
        .dm_ack_o(dm_ack[1]), .dm_rdata_o(dm_rdata[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1]), .owner_o(owner[1]));

    // Unwritten words read back an address-dependent pattern; word 0x004 holds 0xDEADBEEF.
    function automatic logic [DW-1:0] minit(input logic [AW-1:0] a);
        if (a == 12'h004) return 32'hDEADBEEF;
        return 32'hA500_0000 ^ {8'h00, a, a};
    endfunction

    logic [DW-1:0] mem  [2][4096];
    bit            wr   [2][4096];
    logic [DW-1:0] pipe [2][16];
    int unsigned   cyc = 0;

    // Read data emerges L cycles after the strobe; non-strobe cycles push junk.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 15; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
            if (mem_en[k]) begin
                pipe[k][0] <= wr[k][mem_addr[k]] ? mem[k][mem_addr[k]] : minit(mem_addr[k]);
                if (mem_we[k]) begin
                    mem[k][mem_addr[k]] <= mem_wdata[k];
                    wr[k][mem_addr[k]]  <= 1'b1;
                end
            end else begin
                pipe[k][0] <= 32'hBAD0_0000 | cyc;
            end
        end
    end
    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst, ifr;
        logic [AW-1:0] ifa;
        logic          dmr, dmw;
        logic [AW-1:0] dma;
        logic [DW-1:0] dmwd;
        logic          en, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          ifack, dmack, bsy, own;
        logic [DW-1:0] ifrd, dmrd;
    } vec_t;

    function automatic vec_t mk(input logic rst, ifr, input logic [AW-1:0] ifa,
                                input logic dmr, dmw, input logic [AW-1:0] dma, input logic [DW-1:0] dmwd,
                                input logic en, we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                input logic ifack, dmack, bsy, own, input logic [DW-1:0] ifrd, dmrd);
        vec_t v;
        v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dmw = dmw; v.dma = dma; v.dmwd = dmwd;
        v.en = en; v.we = we; v.addr = addr; v.wd = wd; v.ifack = ifack; v.dmack = dmack;
        v.bsy = bsy; v.own = own; v.ifrd = ifrd; v.dmrd = dmrd;
        return v;
    endfunction

    task automatic run_table();
        vec_t tbl [28];
        logic [DW-1:0] D = 32'hDEADBEEF;
        logic [DW-1:0] S = 32'h12345678;
        for (int r = 0; r < 3; r++) tbl[r] = mk(0,1,'h004,1,0,'h010,0, 0,0,'h000,0, 0,0,0,0, 0,0);
        tbl[3]  = mk(1,1,'h004,0,0,'h000,0, 1,0,'h004,0, 0,0,1,0, 0,0);
        tbl[4]  = mk(1,1,'h004,0,0,'h000,0, 0,0,'h004,0, 0,0,1,0, 0,0);
        tbl[5]  = mk(1,1,'h004,0,0,'h000,0, 0,0,'h004,0, 1,0,1,0, D,0);
        tbl[6]  = mk(1,0,'h004,0,0,'h000,0, 0,0,'h004,0, 0,0,0,0, D,0);
        tbl[7]  = mk(1,0,'h000,1,1,'h010,S, 1,1,'h010,S, 0,0,1,1, D,0);
        tbl[8]  = mk(1,0,'h000,1,1,'h010,S, 0,1,'h010,S, 0,0,1,1, D,0);
        tbl[9]  = mk(1,0,'h000,1,1,'h010,S, 0,1,'h010,S, 0,1,1,1, D,0);
        tbl[10] = mk(1,0,'h000,0,1,'h010,S, 0,1,'h010,S, 0,0,0,1, D,0);
        tbl[11] = mk(0,1,'h004,1,0,'h010,0, 0,0,'h000,0, 0,0,0,0, 0,0);
        tbl[12] = mk(1,1,'h004,1,0,'h010,0, 1,0,'h004,0, 0,0,1,0, 0,0);
        tbl[13] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h004,0, 0,0,1,0, 0,0);
        tbl[14] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h004,0, 1,0,1,0, D,0);
        tbl[15] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h004,0, 0,0,0,0, D,0);
        tbl[16] = mk(1,1,'h004,1,0,'h010,0, 1,0,'h010,0, 0,0,1,1, D,0);
        tbl[17] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h010,0, 0,0,1,1, D,0);
        tbl[18] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h010,0, 0,1,1,1, D,S);
        tbl[19] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h010,0, 0,0,0,1, D,S);
        tbl[20] = mk(1,1,'h004,1,0,'h010,0, 1,0,'h004,0, 0,0,1,0, D,S);
        tbl[21] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h004,0, 0,0,1,0, D,S);
        tbl[22] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h004,0, 1,0,1,0, D,S);
        tbl[23] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h004,0, 0,0,0,0, D,S);
        tbl[24] = mk(1,1,'h004,1,0,'h010,0, 1,0,'h010,0, 0,0,1,1, D,S);
        tbl[25] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h010,0, 0,0,1,1, D,S);
        tbl[26] = mk(1,1,'h004,1,0,'h010,0, 0,0,'h010,0, 0,1,1,1, D,S);
        tbl[27] = mk(1,0,'h004,0,0,'h010,0, 0,0,'h010,0, 0,0,0,1, D,S);
        for (int r = 0; r < 28; r++) begin
            reset_n[0] = tbl[r].rst;  if_req[0] = tbl[r].ifr; if_addr[0] = tbl[r].ifa;
            dm_req[0]  = tbl[r].dmr;  dm_we[0]  = tbl[r].dmw; dm_addr[0] = tbl[r].dma;
            dm_wdata[0] = tbl[r].dmwd;
            @(posedge clk); #1;
            check($sformatf("row%0d_mem_en", r), mem_en[0], tbl[r].en);
            check($sformatf("row%0d_if_ack", r), if_ack[0], tbl[r].ifack);
            check($sformatf("row%0d_dm_ack", r), dm_ack[0], tbl[r].dmack);
            check($sformatf("row%0d_busy", r), busy[0], tbl[r].bsy);
            check($sformatf("row%0d_owner", r), owner[0], tbl[r].own);
            check($sformatf("row%0d_if_rdata", r), if_rdata[0], tbl[r].ifrd);
            check($sformatf("row%0d_dm_rdata", r), dm_rdata[0], tbl[r].dmrd);
            if (tbl[r].bsy || !tbl[r].rst) begin
                check($sformatf("row%0d_mem_addr", r), mem_addr[0], tbl[r].addr);
                check($sformatf("row%0d_mem_we", r), mem_we[0], tbl[r].we);
            end
            if (tbl[r].en && tbl[r].we)
                check($sformatf("row%0d_mem_wdata", r), mem_wdata[0], tbl[r].wd);
        end
    endtask

    task automatic reset_dut(input int k);
        reset_n[k] = 1'b0; if_req[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n[k] = 1'b1;
    endtask

    // Latency-3 load timing, then reset in WAIT abandoning the transaction.
    task automatic run_latency3();
        logic [DW-1:0] seen = '0;
        int n_late = 0;
        bit got;
        reset_dut(1);
        dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 12'h030;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("l3_mem_en_c%0d", c), mem_en[1], c == 1);
            check($sformatf("l3_dm_ack_c%0d", c), dm_ack[1], c == 5);
            if (c <= 5) check($sformatf("l3_mem_addr_c%0d", c), mem_addr[1], 12'h030);
            if (c == 4) seen = mem_rdata[1];
            if (c == 5) begin
                check("l3_rdata_vs_bus", dm_rdata[1], seen);
                check("l3_rdata_value", dm_rdata[1], minit(12'h030));
                dm_req[1] = 1'b0;
            end
            if (c == 6) check("l3_busy_after", busy[1], 0);
        end
        if_req[1] = 1'b1; if_addr[1] = 12'h200;
        @(posedge clk); #1;
        check("rst_wait_issue", mem_en[1], 1);
        @(posedge clk); #1;
        reset_n[1] = 1'b0;
        @(posedge clk); #1;
        check("rst_wait_busy", busy[1], 0);
        check("rst_wait_owner", owner[1], 0);
        check("rst_wait_dm_rdata", dm_rdata[1], 0);
        reset_n[1] = 1'b1; if_req[1] = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (if_ack[1] || dm_ack[1]) n_late++;
        end
        check("rst_wait_no_ack", n_late, 0);
        if_req[1] = 1'b1; dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 12'h030;
        @(posedge clk); #1;
        check("rst_tie_owner", owner[1], 0);
        check("rst_tie_addr", mem_addr[1], 12'h200);
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(posedge clk); #1;
            if (if_ack[1]) begin got = 1'b1; if_req[1] = 1'b0; end
        end
        check("rst_tie_if_ack", got, 1);
        check("rst_tie_if_rdata", if_rdata[1], minit(12'h200));
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(posedge clk); #1;
            if (dm_ack[1]) begin got = 1'b1; dm_req[1] = 1'b0; end
        end
        check("rst_tie_dm_ack", got, 1);
    endtask

    // Random traffic: IF reads 0x200-0x2FF (never written), DM loads/stores 0x100-0x10F.
    task automatic run_random(input int k, input int ncyc);
        int lat = (k == 0) ? 1 : 3;
        int bound = 2 * (lat + 3) + 4;
        bit if_p = 0, dm_p = 0, if_blk = 0, dm_blk = 0, dm_st = 0;
        int if_age = 0, dm_age = 0, n_en = 0, n_ack = 0;
        int n_ovl = 0, n_unfair = 0, n_tmo = 0, n_spur = 0;
        logic [DW-1:0] if_exp = '0, dm_exp = '0, dm_last = '0;
        logic [DW-1:0] shadow [16];
        bit            sv [16];
        logic [AW-1:0] a;
        for (int i = 0; i < 16; i++) sv[i] = 1'b0;
        reset_dut(k);
        for (int c = 0; c < ncyc + 60; c++) begin
            if (!if_p && c < ncyc && $urandom_range(1, 0) == 1) begin
                if_addr[k] = 12'h200 | 12'($urandom_range(255));
                if_exp = minit(if_addr[k]);
                if_req[k] = 1'b1; if_p = 1'b1; if_age = 0;
            end
            if (!dm_p && c < ncyc && $urandom_range(1, 0) == 1) begin
                a = 12'h100 | 12'($urandom_range(15));
                dm_st = ($urandom_range(1, 0) == 1);
                dm_addr[k] = a; dm_we[k] = dm_st;
                if (dm_st) begin
                    dm_wdata[k] = $urandom;
                    shadow[a[3:0]] = dm_wdata[k]; sv[a[3:0]] = 1'b1;
                    dm_exp = dm_last;
                end else begin
                    dm_exp = sv[a[3:0]] ? shadow[a[3:0]] : minit(a);
                end
                dm_req[k] = 1'b1; dm_p = 1'b1; dm_age = 0;
            end
            @(posedge clk); #1;
            if (mem_en[k]) n_en++;
            if (if_ack[k] && dm_ack[k]) n_ovl++;
            if (if_ack[k]) begin
                n_ack++;
                if (!if_p) n_spur++;
                else begin
                    check($sformatf("rnd%0d_if_rdata", k), if_rdata[k], if_exp);
                    if (if_blk) n_unfair++;
                    if_blk = dm_p; dm_blk = 1'b0;
                    if_p = 1'b0; if_req[k] = 1'b0;
                end
            end
            if (dm_ack[k]) begin
                n_ack++;
                if (!dm_p) n_spur++;
                else begin
                    check($sformatf("rnd%0d_dm_rdata", k), dm_rdata[k], dm_exp);
                    if (!dm_st) dm_last = dm_exp;
                    if (dm_blk) n_unfair++;
                    dm_blk = if_p; if_blk = 1'b0;
                    dm_p = 1'b0; dm_req[k] = 1'b0;
                end
            end
            if (if_p && ++if_age > bound) begin n_tmo++; if_p = 1'b0; if_req[k] = 1'b0; end
            if (dm_p && ++dm_age > bound) begin n_tmo++; dm_p = 1'b0; dm_req[k] = 1'b0; end
        end
        check($sformatf("rnd%0d_ack_overlap", k), n_ovl, 0);
        check($sformatf("rnd%0d_round_robin", k), n_unfair, 0);
        check($sformatf("rnd%0d_timeout", k), n_tmo, 0);
        check($sformatf("rnd%0d_spurious_ack", k), n_spur, 0);
        check($sformatf("rnd%0d_strobes_vs_acks", k), n_en, n_ack);
        check($sformatf("rnd%0d_activity", k), n_ack > 20, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset_n[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0; dm_req[k] = 1'b0;
            dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0;
        end
        run_table();
        run_latency3();
        run_random(0, 400);
        run_random(1, 400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
